// File: rtl/bf16_matmul_sequencer_if.sv
// Control/address bus between the matmul sequencer and its operand memories,
// the bf16 multiplier/accumulator and the C result memory.
interface bf16_matmul_sequencer_if #(
  parameter int AW = 8
);
  logic          start;
  logic          stall;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic          mul_valid;
  logic          acc_clear;
  logic          acc_last;
  logic          c_we;
  logic [AW-1:0] c_addr;

  modport master (
    input  start, stall,
    output busy, done, rd_en, a_addr, b_addr,
    output mul_valid, acc_clear, acc_last, c_we, c_addr
  );

  modport slave (
    output start, stall,
    input  busy, done, rd_en, a_addr, b_addr,
    input  mul_valid, acc_clear, acc_last, c_we, c_addr
  );
endinterface

// File: rtl/bf16_matmul_sequencer.sv
// Sequences one C = A*B pass: issues A/B reads row-major over C with k fastest,
// tags each product as first/last term and strobes C writes two stages later.
module bf16_matmul_sequencer #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int AW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  bf16_matmul_sequencer_if.master bus
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [KW-1:0]   k_q, k_d;
  logic            drain_q, drain_d;
  logic            rd_en;
  logic [AW-1:0]   cidx;

  // stage p0: memory read in flight; stage p1: accumulator result ready
  logic            vld_p0_q;
  logic            clr_p0_q;
  logic            last_p0_q;
  logic [AW-1:0]   cidx_p0_q;
  logic            we_p1_q;
  logic [AW-1:0]   caddr_p1_q;

  logic k_end, j_end, i_end;
  assign k_end = (k_q == KW'(K - 1));
  assign j_end = (j_q == JW'(N - 1));
  assign i_end = (i_q == IW'(M - 1));

  // Address products are formed at 32 bits, then truncated to the port width.
  assign bus.a_addr = AW'(int'(i_q) * K + int'(k_q));
  assign bus.b_addr = AW'(int'(k_q) * N + int'(j_q));
  assign cidx       = AW'(int'(i_q) * N + int'(j_q));

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    drain_d = drain_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          rd_en = 1'b1;
          if (k_end && j_end && i_end) begin
            state_d = DRAIN;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            drain_d = 1'b0;
          end else if (!k_end) begin
            k_d = k_q + KW'(1);
          end else begin
            k_d = '0;
            if (!j_end) begin
              j_d = j_q + JW'(1);
            end else begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end
          end
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // Reset clears the pipeline too so nothing issued before it can write C.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q   <= 1'b0;
      clr_p0_q   <= 1'b0;
      last_p0_q  <= 1'b0;
      cidx_p0_q  <= '0;
      we_p1_q    <= 1'b0;
      caddr_p1_q <= '0;
    end else begin
      vld_p0_q  <= rd_en;
      clr_p0_q  <= rd_en && (k_q == '0);
      last_p0_q <= rd_en && k_end;
      if (rd_en) cidx_p0_q <= cidx;
      we_p1_q   <= vld_p0_q && last_p0_q;
      if (vld_p0_q && last_p0_q) caddr_p1_q <= cidx_p0_q;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.rd_en     = rd_en;
  assign bus.mul_valid = vld_p0_q;
  assign bus.acc_clear = clr_p0_q;
  assign bus.acc_last  = last_p0_q;
  assign bus.c_we      = we_p1_q;
  assign bus.c_addr    = caddr_p1_q;

endmodule

// File: tb/tb_bf16_matmul_sequencer.sv
// Directed bench for the matmul sequencer: 2x2x2 and 2x2x1 cycle-exact passes
// plus randomly stalled 4x4x4 passes checked against an integer matmul.
module tb_bf16_matmul_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bf16_matmul_sequencer_if #(.AW(8)) ifa ();
  bf16_matmul_sequencer_if #(.AW(8)) ifb ();
  bf16_matmul_sequencer_if #(.AW(8)) ifc ();

  bf16_matmul_sequencer #(.M(2), .N(2), .K(2), .AW(8)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  bf16_matmul_sequencer #(.M(2), .N(2), .K(1), .AW(8)) u_b (.clk(clk), .rst(rst), .bus(ifb));
  bf16_matmul_sequencer #(.M(4), .N(4), .K(4), .AW(8)) u_c (.clk(clk), .rst(rst), .bus(ifc));

  logic [1:0] sel;
  logic       start_v, stall_v;
  assign ifa.start = (sel == 2'd0) && start_v;
  assign ifa.stall = (sel == 2'd0) && stall_v;
  assign ifb.start = (sel == 2'd1) && start_v;
  assign ifb.stall = (sel == 2'd1) && stall_v;
  assign ifc.start = (sel == 2'd2) && start_v;
  assign ifc.stall = (sel == 2'd2) && stall_v;

  logic       o_busy, o_done, o_rd, o_mv, o_clr, o_last, o_we;
  logic [7:0] o_a, o_b, o_c;
  always_comb begin
    o_busy = ifa.busy; o_done = ifa.done; o_rd = ifa.rd_en; o_mv = ifa.mul_valid;
    o_clr = ifa.acc_clear; o_last = ifa.acc_last; o_we = ifa.c_we;
    o_a = ifa.a_addr; o_b = ifa.b_addr; o_c = ifa.c_addr;
    if (sel == 2'd1) begin
      o_busy = ifb.busy; o_done = ifb.done; o_rd = ifb.rd_en; o_mv = ifb.mul_valid;
      o_clr = ifb.acc_clear; o_last = ifb.acc_last; o_we = ifb.c_we;
      o_a = ifb.a_addr; o_b = ifb.b_addr; o_c = ifb.c_addr;
    end else if (sel == 2'd2) begin
      o_busy = ifc.busy; o_done = ifc.done; o_rd = ifc.rd_en; o_mv = ifc.mul_valid;
      o_clr = ifc.acc_clear; o_last = ifc.acc_last; o_we = ifc.c_we;
      o_a = ifc.a_addr; o_b = ifc.b_addr; o_c = ifc.c_addr;
    end
  end

  int vectors = 0;
  int misc    = 0;
  int cyc_g   = 0;
  int ea[16];
  int eb[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc_g, obs, exp);
    end
  endtask

  // One directed pass on the selected small DUT; masks give per-cycle inputs and
  // expected strobes, ea/eb give the expected issue order.
  task automatic run_pass(input string tag, input int kk, input int ncyc,
                          input logic [31:0] start_m, input logic [31:0] stall_m,
                          input logic [31:0] rst_m, input logic [31:0] rd_m,
                          input logic [31:0] we_m, input logic [31:0] done_m,
                          input logic [31:0] busy_m);
    int  n = 0, cw = 0, pk = 0;
    bit  prd = 0, prst = 0, post = 0;
    logic mv_e;
    for (int c = 0; c < ncyc; c++) begin
      cyc_g   = c;
      start_v = start_m[c];
      stall_v = stall_m[c];
      rst     = rst_m[c];
      #1;
      chk({tag, "_rd"},   o_rd,   rd_m[c]);
      chk({tag, "_busy"}, o_busy, busy_m[c]);
      chk({tag, "_done"}, o_done, done_m[c]);
      chk({tag, "_cwe"},  o_we,   we_m[c]);
      mv_e = prd && !prst;
      chk({tag, "_mv"},   o_mv,   mv_e);
      chk({tag, "_clr"},  o_clr,  mv_e && (pk == 0));
      chk({tag, "_last"}, o_last, mv_e && (pk == kk - 1));
      prd = rd_m[c];
      prst = rst_m[c];
      if (rd_m[c]) begin
        chk({tag, "_aaddr"}, o_a, ea[n]);
        chk({tag, "_baddr"}, o_b, eb[n]);
        pk = n % kk;
        n++;
      end
      if (we_m[c]) begin
        chk({tag, "_caddr"}, o_c, cw);
        cw++;
      end
      if (post) begin
        chk({tag, "_rst_a"}, o_a, 0);
        chk({tag, "_rst_b"}, o_b, 0);
        chk({tag, "_rst_c"}, o_c, 0);
      end
      if (rst_m[c]) post = 1;
      @(posedge clk);
      #1;
    end
    start_v = 0;
    stall_v = 0;
    rst     = 0;
  endtask

  int amem[16], bmem[16], cref[16];
  int da, db, acc, pend, cyc, rdcnt, wecnt, mi, mj, mk;
  bit fin, prd_r;

  initial begin
    rst = 1; sel = 0; start_v = 0; stall_v = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0); chk("rst_rd", o_rd, 0);
      chk("rst_mv", o_mv, 0); chk("rst_clr", o_clr, 0); chk("rst_last", o_last, 0);
      chk("rst_cwe", o_we, 0); chk("rst_a", o_a, 0); chk("rst_b", o_b, 0); chk("rst_c", o_c, 0);
    end
    @(posedge clk); #1;

    sel = 0;
    ea = '{0,1,0,1,2,3,2,3,0,0,0,0,0,0,0,0};
    eb = '{0,2,1,3,0,2,1,3,0,0,0,0,0,0,0,0};
    run_pass("base",    2, 13, 32'h1, 32'h0,  32'h0,  32'h1FE, 32'h550,  32'h800,  32'hFFE);
    run_pass("stall",   2, 16, 32'h1, 32'h38, 32'h0,  32'hFC6, 32'h2A10, 32'h4000, 32'h7FFE);
    run_pass("ststart", 2, 14, 32'h1, 32'h3,  32'h0,  32'h3FC, 32'hAA0,  32'h1000, 32'h1FFE);
    run_pass("restart", 2, 14, 32'h205, 32'h0, 32'h0, 32'h1FE, 32'h550,  32'h800,  32'hFFE);
    run_pass("midrst",  2, 8,  32'h1, 32'h0,  32'h20, 32'h3E,  32'h10,   32'h0,    32'h3E);
    run_pass("afterrst",2, 13, 32'h1, 32'h0,  32'h0,  32'h1FE, 32'h550,  32'h800,  32'hFFE);

    sel = 1;
    ea = '{0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0};
    eb = '{0,1,0,1,0,0,0,0,0,0,0,0,0,0,0,0};
    run_pass("k1",      1, 9,  32'h1, 32'h0,  32'h0,  32'h1E,  32'h78,   32'h80,   32'hFE);

    // Randomly stalled 4x4x4 passes with small-integer operands (exact in bf16).
    sel = 2;
    for (int p = 0; p < 100; p++) begin
      for (int x = 0; x < 16; x++) begin
        amem[x] = int'($urandom_range(0, 7));
        bmem[x] = int'($urandom_range(0, 7));
      end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          cref[i*4+j] = 0;
          for (int k = 0; k < 4; k++) cref[i*4+j] += amem[i*4+k] * bmem[k*4+j];
        end
      fin = 0; cyc = 0; rdcnt = 0; wecnt = 0; mi = 0; mj = 0; mk = 0;
      acc = 0; pend = 0; da = 0; db = 0; prd_r = 0;
      start_v = 1;
      while (!fin && cyc < 400) begin
        cyc_g   = cyc;
        stall_v = 1'($urandom_range(0, 1));
        #1;
        if (cyc > 0) chk("rnd_mv", o_mv, prd_r);
        if (o_we) begin
          chk("rnd_caddr", o_c, wecnt);
          chk("rnd_cdata", pend, cref[wecnt[3:0]]);
          wecnt++;
        end
        if (o_mv) begin
          acc = o_clr ? da * db : acc + da * db;
          if (o_last) pend = acc;
        end
        prd_r = o_rd;
        if (o_rd) begin
          chk("rnd_aaddr", o_a, mi*4 + mk);
          chk("rnd_baddr", o_b, mk*4 + mj);
          da = amem[o_a[3:0]];
          db = bmem[o_b[3:0]];
          rdcnt++;
          if (mk < 3) mk++;
          else begin
            mk = 0;
            if (mj < 3) mj++;
            else begin mj = 0; mi++; end
          end
        end
        if (o_done) fin = 1;
        @(posedge clk);
        #1;
        start_v = 0;
        cyc++;
      end
      stall_v = 0;
      chk("rnd_finished", fin, 1);
      chk("rnd_rdcount", rdcnt, 64);
      chk("rnd_wecount", wecnt, 16);
      #1;
      chk("rnd_idle", o_busy, 0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule

// File: doc/bf16_matmul_sequencer.md
BF16_MATMUL_SEQUENCER -- requirements
Module: bf16_matmul_sequencer

Interface
REQ-001 Parameter M, default 4: rows of A and C.
REQ-002 Parameter N, default 4: columns of B and C.
REQ-003 Parameter K, default 4: columns of A and rows of B (dot-product length).
REQ-004 Parameter AW, default 8: width of every address port.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request one full C = A*B pass; sampled only in IDLE.
REQ-008 stall  input  1  freezes operand issue while high.
REQ-009 busy  output  1  high from first cycle after accepted start through the done cycle.
REQ-010 done  output  1  one-cycle pulse at end of pass.
REQ-011 rd_en  output  1  A/B memory read strobe; addresses valid this cycle.
REQ-012 a_addr  output  AW  A element address, i*K+k.
REQ-013 b_addr  output  AW  B element address, k*N+j.
REQ-014 mul_valid  output  1  bf16 multiplier operands (memory read data) valid this cycle.
REQ-015 acc_clear  output  1  with mul_valid: product is first term (k==0); accumulator loads instead of adds.
REQ-016 acc_last  output  1  with mul_valid: product is last term (k==K-1).
REQ-017 c_we  output  1  accumulator result write strobe to C memory.
REQ-018 c_addr  output  AW  C element address, i*N+j.

Function
REQ-019 States: IDLE, RUN, DRAIN, DONE; encoding free.
REQ-020 IDLE->RUN on start==1; counters i,j,k load 0; start ignored in all other states.
REQ-021 RUN, stall==0: rd_en=1, addresses from current (i,j,k), then advance k fastest, then j, then i (row-major over C).
REQ-022 RUN, stall==1: rd_en=0, counters hold; in-flight pipeline stages still advance.
REQ-023 Counter wrap: k==K-1 -> k=0, j+1; additionally j==N-1 -> j=0, i+1.
REQ-024 Issue of (M-1,N-1,K-1) moves RUN->DRAIN; no further rd_en in the pass.
REQ-025 Memory read latency is fixed at 1 cycle: mul_valid, acc_clear, acc_last are rd_en, (k==0), (k==K-1) delayed one register stage.
REQ-026 acc_clear and acc_last are 0 whenever mul_valid is 0; both 1 together when K==1.
REQ-027 c_we is asserted the cycle after mul_valid&&acc_last; c_addr is the i*N+j of that element, delayed two stages with the issue.
REQ-028 DRAIN lasts exactly 2 cycles (empties the two stages), then DONE.
REQ-029 DONE lasts 1 cycle with done=1, busy=1; then IDLE, busy=0.
REQ-030 Exactly M*N*K rd_en pulses and M*N c_we pulses per pass, c_addr ascending 0..M*N-1.
REQ-031 Address arithmetic in widths wide enough for M*K-1, K*N-1, M*N-1; each truncated to AW; M*K, K*N, M*N <= 2**AW is a usage requirement.
REQ-032 Minimum pass length with stall==0: M*N*K+3 cycles from first issue to done inclusive.
REQ-033 start and stall together in IDLE: start accepted; first RUN cycle honours stall.

Reset
REQ-034 rst has priority over all inputs; next state IDLE, i=j=k=0.
REQ-035 After reset busy, done, rd_en, mul_valid, acc_clear, acc_last, c_we = 0; a_addr, b_addr, c_addr = 0.
REQ-036 Reset mid-pass discards all in-flight stages: no c_we or done after the reset edge.

Verification
REQ-037 M=N=K=2, start at cycle 0, stall=0 -> rd_en cycles 1-8, a_addr 0,1,0,1,2,3,2,3, b_addr 0,2,1,3,0,2,1,3; c_we cycles 4,6,8,10 with c_addr 0,1,2,3; done at cycle 11 only.
REQ-038 Same config, stall=1 cycles 3-5 -> rd_en off cycles 3-5, issue order unchanged, done at cycle 14, still 8 rd_en and 4 c_we.
REQ-039 K=1, M=N=2 -> every mul_valid has acc_clear=acc_last=1; c_we on the 4 cycles following each rd_en; done at cycle 7.
REQ-040 start pulsed in cycles 2 and 9 of a running pass -> ignored; single pass, single done.
REQ-041 rst at cycle 5 of a pass -> all outputs 0 from cycle 6; no c_we/done; new start at cycle 8 gives full correct pass.
REQ-042 Random stall over 100 passes with default parameters -> 64 rd_en and 16 c_we per pass, c_addr 0..15 in order, scoreboard match against reference matmul of bf16 products.
